// File: rtl/ex_stage_pkg.sv
// Shared definitions for the EX stage: ALU opcodes, access sizes, multiplier FSM states
// and the EX/MEM pipeline register layout.
package ex_stage_pkg;

  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluAnd  = 4'd2,
    AluOr   = 4'd3,
    AluXor  = 4'd4,
    AluNor  = 4'd5,
    AluSlt  = 4'd6,
    AluSltu = 4'd7,
    AluSll  = 4'd8,
    AluSrl  = 4'd9,
    AluSra  = 4'd10,
    AluLui  = 4'd11,
    AluMul  = 4'd12
  } alu_op_e;

  typedef enum logic [1:0] {
    MemNone = 2'b00,
    MemWord = 2'b01,
    MemHalf = 2'b10,
    MemByte = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } mul_state_e;

  localparam int unsigned Xlen = 32;
  localparam logic [4:0] MulLastIter = 5'd31;

  typedef struct packed {
    logic [Xlen-1:0] pc_branched;
    logic [Xlen-1:0] alu;
    logic [Xlen-1:0] b;
    logic            do_branch;
    logic [4:0]      reg_write_address;
    logic            branch;
    logic [1:0]      mem_read;
    logic [1:0]      mem_write;
    logic            reg_write;
    logic            mem_to_reg;
  } exmem_t;

  // Branch offsets are word counts relative to PC+4.
  function automatic logic [Xlen-1:0] branch_target(logic [Xlen-1:0] pc, logic [Xlen-1:0] imm);
    return pc + (imm << 2);
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage; master is the pipeline side that
// drives ID/EX, slave is the execute stage itself.
interface ex_stage_if;
  logic [31:0] IDEX_pc_i;
  logic [31:0] IDEX_a_i;
  logic [31:0] IDEX_b_i;
  logic [31:0] IDEX_imm_i;
  logic [4:0]  IDEX_rt_i;
  logic [4:0]  IDEX_rd_i;
  logic [3:0]  IDEX_ctrl_alu_op_i;
  logic        IDEX_ctrl_alu_src_i;
  logic        IDEX_ctrl_reg_dst_i;
  logic        IDEX_ctrl_branch_i;
  logic        IDEX_ctrl_branch_ne_i;
  logic [1:0]  IDEX_ctrl_mem_read_i;
  logic [1:0]  IDEX_ctrl_mem_write_i;
  logic        IDEX_ctrl_reg_write_i;
  logic        IDEX_ctrl_mem_to_reg_i;

  logic [31:0] EXMEM_pc_branched_o;
  logic [31:0] EXMEM_alu_o;
  logic [31:0] EXMEM_b_o;
  logic        EXMEM_alu_do_branch_o;
  logic [4:0]  EXMEM_reg_write_address_o;
  logic        EXMEM_ctrl_branch_o;
  logic [1:0]  EXMEM_ctrl_mem_read_o;
  logic [1:0]  EXMEM_ctrl_mem_write_o;
  logic        EXMEM_ctrl_reg_write_o;
  logic        EXMEM_ctrl_mem_to_reg_o;

  modport master (
    output IDEX_pc_i, IDEX_a_i, IDEX_b_i, IDEX_imm_i, IDEX_rt_i, IDEX_rd_i,
    output IDEX_ctrl_alu_op_i, IDEX_ctrl_alu_src_i, IDEX_ctrl_reg_dst_i,
    output IDEX_ctrl_branch_i, IDEX_ctrl_branch_ne_i, IDEX_ctrl_mem_read_i,
    output IDEX_ctrl_mem_write_i, IDEX_ctrl_reg_write_i, IDEX_ctrl_mem_to_reg_i,
    input  EXMEM_pc_branched_o, EXMEM_alu_o, EXMEM_b_o, EXMEM_alu_do_branch_o,
    input  EXMEM_reg_write_address_o, EXMEM_ctrl_branch_o, EXMEM_ctrl_mem_read_o,
    input  EXMEM_ctrl_mem_write_o, EXMEM_ctrl_reg_write_o, EXMEM_ctrl_mem_to_reg_o
  );

  modport slave (
    input  IDEX_pc_i, IDEX_a_i, IDEX_b_i, IDEX_imm_i, IDEX_rt_i, IDEX_rd_i,
    input  IDEX_ctrl_alu_op_i, IDEX_ctrl_alu_src_i, IDEX_ctrl_reg_dst_i,
    input  IDEX_ctrl_branch_i, IDEX_ctrl_branch_ne_i, IDEX_ctrl_mem_read_i,
    input  IDEX_ctrl_mem_write_i, IDEX_ctrl_reg_write_i, IDEX_ctrl_mem_to_reg_i,
    output EXMEM_pc_branched_o, EXMEM_alu_o, EXMEM_b_o, EXMEM_alu_do_branch_o,
    output EXMEM_reg_write_address_o, EXMEM_ctrl_branch_o, EXMEM_ctrl_mem_read_o,
    output EXMEM_ctrl_mem_write_o, EXMEM_ctrl_reg_write_o, EXMEM_ctrl_mem_to_reg_o
  );
endinterface

// File: rtl/ex_stage_mul_unit.sv
// Radix-2 shift-add multiplier producing the low 32 bits of the product; one iteration per
// cycle, 32 iterations, then a single DONE cycle while the product is consumed.
module mul_unit
  import ex_stage_pkg::*;
(
  input  logic            clk_i,
  input  logic            n_rst_i,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [Xlen-1:0] multiplicand_i,
  input  logic [Xlen-1:0] multiplier_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [Xlen-1:0] product_o
);

  mul_state_e      state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [Xlen-1:0] mcand_q, mcand_d;
  logic [Xlen-1:0] mplier_q, mplier_d;
  logic [Xlen-1:0] acc_q, acc_d;

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          mcand_d  = multiplicand_i;
          mplier_d = multiplier_i;
          acc_d    = '0;
          cnt_d    = MulLastIter;
          state_d  = StBusy;
        end
      end
      StBusy: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // A flush kills the operation in any state, including the cycle it would complete.
    if (abort_i) begin
      state_d = StIdle;
    end
  end

  assign busy_o    = (state_q == StBusy);
  assign done_o    = (state_q == StDone);
  assign product_o = acc_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: combinational ALU and branch resolution, multi-cycle MUL via mul_unit,
// and the EX/MEM pipeline register with bubble insertion on stall or flush.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic       clk_i,
  input  logic       n_rst_i,
  input  logic       flush_i,
  output logic       EX_stall_o,
  ex_stage_if.slave  ex_if
);

  alu_op_e         alu_op;
  logic [Xlen-1:0] op_a;
  logic [Xlen-1:0] op_b;
  logic [4:0]      shamt;
  logic [Xlen-1:0] alu_result;
  logic            is_mul;
  logic            mul_start;
  logic            mul_busy;
  logic            mul_done;
  logic [Xlen-1:0] mul_product;
  logic            bubble;
  exmem_t          exmem_q, exmem_d;

  assign alu_op = alu_op_e'(ex_if.IDEX_ctrl_alu_op_i);
  assign op_a   = ex_if.IDEX_a_i;
  assign op_b   = ex_if.IDEX_ctrl_alu_src_i ? ex_if.IDEX_imm_i : ex_if.IDEX_b_i;
  assign shamt  = op_b[4:0];

  always_comb begin
    alu_result = '0;
    case (alu_op)
      AluAdd:  alu_result = op_a + op_b;
      AluSub:  alu_result = op_a - op_b;
      AluAnd:  alu_result = op_a & op_b;
      AluOr:   alu_result = op_a | op_b;
      AluXor:  alu_result = op_a ^ op_b;
      AluNor:  alu_result = ~(op_a | op_b);
      AluSlt:  alu_result = {31'd0, $signed(op_a) < $signed(op_b)};
      AluSltu: alu_result = {31'd0, op_a < op_b};
      AluSll:  alu_result = op_a << shamt;
      AluSrl:  alu_result = op_a >> shamt;
      AluSra:  alu_result = $unsigned($signed(op_a) >>> shamt);
      AluLui:  alu_result = op_b << 16;
      default: alu_result = '0;
    endcase
  end

  assign is_mul    = (alu_op == AluMul);
  assign mul_start = is_mul & ~mul_busy & ~mul_done & ~flush_i;

  mul_unit u_mul_unit (
    .clk_i          (clk_i),
    .n_rst_i        (n_rst_i),
    .start_i        (mul_start),
    .abort_i        (flush_i),
    .multiplicand_i (op_a),
    .multiplier_i   (op_b),
    .busy_o         (mul_busy),
    .done_o         (mul_done),
    .product_o      (mul_product)
  );

  // MUL holds the front of the pipe until its DONE cycle; flush and reset win over that.
  assign bubble     = flush_i | (is_mul & ~mul_done);
  assign EX_stall_o = n_rst_i & ~flush_i & is_mul & ~mul_done;

  always_comb begin
    exmem_d = exmem_q;
    if (bubble) begin
      exmem_d.do_branch  = 1'b0;
      exmem_d.branch     = 1'b0;
      exmem_d.mem_read   = MemNone;
      exmem_d.mem_write  = MemNone;
      exmem_d.reg_write  = 1'b0;
      exmem_d.mem_to_reg = 1'b0;
    end else begin
      exmem_d.pc_branched = branch_target(ex_if.IDEX_pc_i, ex_if.IDEX_imm_i);
      exmem_d.alu         = is_mul ? mul_product : alu_result;
      exmem_d.b           = ex_if.IDEX_b_i;
      exmem_d.do_branch   = ex_if.IDEX_ctrl_branch_ne_i ? (ex_if.IDEX_a_i != ex_if.IDEX_b_i)
                                                        : (ex_if.IDEX_a_i == ex_if.IDEX_b_i);
      exmem_d.reg_write_address = ex_if.IDEX_ctrl_reg_dst_i ? ex_if.IDEX_rd_i : ex_if.IDEX_rt_i;
      exmem_d.branch      = ex_if.IDEX_ctrl_branch_i;
      exmem_d.mem_read    = ex_if.IDEX_ctrl_mem_read_i;
      exmem_d.mem_write   = ex_if.IDEX_ctrl_mem_write_i;
      exmem_d.reg_write   = ex_if.IDEX_ctrl_reg_write_i;
      exmem_d.mem_to_reg  = ex_if.IDEX_ctrl_mem_to_reg_i;
    end
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      exmem_q <= '0;
    end else begin
      exmem_q <= exmem_d;
    end
  end

  assign ex_if.EXMEM_pc_branched_o       = exmem_q.pc_branched;
  assign ex_if.EXMEM_alu_o               = exmem_q.alu;
  assign ex_if.EXMEM_b_o                 = exmem_q.b;
  assign ex_if.EXMEM_alu_do_branch_o     = exmem_q.do_branch;
  assign ex_if.EXMEM_reg_write_address_o = exmem_q.reg_write_address;
  assign ex_if.EXMEM_ctrl_branch_o       = exmem_q.branch;
  assign ex_if.EXMEM_ctrl_mem_read_o     = exmem_q.mem_read;
  assign ex_if.EXMEM_ctrl_mem_write_o    = exmem_q.mem_write;
  assign ex_if.EXMEM_ctrl_reg_write_o    = exmem_q.reg_write;
  assign ex_if.EXMEM_ctrl_mem_to_reg_o   = exmem_q.mem_to_reg;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: table of single-cycle ops plus hand-written MUL, flush
// and reset sequences, with expected EX/MEM contents queued at drive time.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic clk_i = 1'b0;
  logic n_rst_i;
  logic flush_i;
  logic EX_stall_o;

  ex_stage_if ex_if ();

  ex_stage u_dut (
    .clk_i      (clk_i),
    .n_rst_i    (n_rst_i),
    .flush_i    (flush_i),
    .EX_stall_o (EX_stall_o),
    .ex_if      (ex_if)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic        src;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        reg_dst;
    logic        br;
    logic        bne;
    logic [1:0]  mr;
    logic [1:0]  mw;
    logic        rw;
    logic        m2r;
  } in_t;

  typedef struct packed {
    logic [31:0] pc_br;
    logic [31:0] alu;
    logic [31:0] b;
    logic        do_br;
    logic [4:0]  wa;
    logic        br;
    logic [1:0]  mr;
    logic [1:0]  mw;
    logic        rw;
    logic        m2r;
  } exp_t;

  typedef struct packed {
    in_t         in;
    logic [31:0] alu;
    logic        do_br;
  } vec_t;

  int    checks   = 0;
  int    failures = 0;
  exp_t  exp_q[$];
  vec_t  vecs[$];
  string names[$];

  function automatic in_t mk_in(logic [3:0] op, logic [31:0] a, logic [31:0] b,
                                logic [31:0] imm, logic src);
    in_t v;
    v = '0;
    v.op = op; v.a = a; v.b = b; v.imm = imm; v.src = src;
    v.pc = 32'h100; v.rt = 5'd3; v.rd = 5'd7; v.reg_dst = 1'b1; v.rw = 1'b1;
    return v;
  endfunction

  function automatic exp_t model(in_t in, logic [31:0] alu, logic do_br);
    exp_t e;
    e.pc_br = in.pc + in.imm * 32'd4;
    e.alu   = alu;
    e.b     = in.b;
    e.do_br = do_br;
    e.wa    = in.reg_dst ? in.rd : in.rt;
    e.br    = in.br;
    e.mr    = in.mr;
    e.mw    = in.mw;
    e.rw    = in.rw;
    e.m2r   = in.m2r;
    return e;
  endfunction

  function automatic exp_t bubble_of(exp_t h);
    exp_t e;
    e = h;
    e.do_br = 1'b0; e.br = 1'b0; e.mr = 2'b00; e.mw = 2'b00; e.rw = 1'b0; e.m2r = 1'b0;
    return e;
  endfunction

  function automatic exp_t sample();
    exp_t s;
    s.pc_br = ex_if.EXMEM_pc_branched_o;
    s.alu   = ex_if.EXMEM_alu_o;
    s.b     = ex_if.EXMEM_b_o;
    s.do_br = ex_if.EXMEM_alu_do_branch_o;
    s.wa    = ex_if.EXMEM_reg_write_address_o;
    s.br    = ex_if.EXMEM_ctrl_branch_o;
    s.mr    = ex_if.EXMEM_ctrl_mem_read_o;
    s.mw    = ex_if.EXMEM_ctrl_mem_write_o;
    s.rw    = ex_if.EXMEM_ctrl_reg_write_o;
    s.m2r   = ex_if.EXMEM_ctrl_mem_to_reg_o;
    return s;
  endfunction

  task automatic drive(input in_t in);
    ex_if.IDEX_pc_i              = in.pc;
    ex_if.IDEX_a_i               = in.a;
    ex_if.IDEX_b_i               = in.b;
    ex_if.IDEX_imm_i             = in.imm;
    ex_if.IDEX_rt_i              = in.rt;
    ex_if.IDEX_rd_i              = in.rd;
    ex_if.IDEX_ctrl_alu_op_i     = in.op;
    ex_if.IDEX_ctrl_alu_src_i    = in.src;
    ex_if.IDEX_ctrl_reg_dst_i    = in.reg_dst;
    ex_if.IDEX_ctrl_branch_i     = in.br;
    ex_if.IDEX_ctrl_branch_ne_i  = in.bne;
    ex_if.IDEX_ctrl_mem_read_i   = in.mr;
    ex_if.IDEX_ctrl_mem_write_i  = in.mw;
    ex_if.IDEX_ctrl_reg_write_i  = in.rw;
    ex_if.IDEX_ctrl_mem_to_reg_i = in.m2r;
  endtask

  task automatic check(input string name, input exp_t want);
    exp_t got;
    got = sample();
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got pc_br=%h alu=%h b=%h dobr=%b wa=%0d ctl=%b/%b/%b/%b/%b, want pc_br=%h alu=%h b=%h dobr=%b wa=%0d ctl=%b/%b/%b/%b/%b",
               name, got.pc_br, got.alu, got.b, got.do_br, got.wa, got.br, got.mr, got.mw,
               got.rw, got.m2r, want.pc_br, want.alu, want.b, want.do_br, want.wa, want.br,
               want.mr, want.mw, want.rw, want.m2r);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic add_vec(input string n, input in_t in, input logic [31:0] alu, input logic dob);
    vec_t v;
    v.in = in; v.alu = alu; v.do_br = dob;
    vecs.push_back(v);
    names.push_back(n);
  endtask

  // MUL with no interference: 33 stall cycles of bubbles holding data, then the product.
  task automatic run_mul(input string name, input in_t in, input logic [31:0] prod);
    exp_t held;
    int   stalls;
    int   bad;
    stalls = 0;
    bad    = 0;
    held   = sample();
    drive(in);
    exp_q.push_back(model(in, prod, 1'b0));
    for (int cyc = 0; cyc < 40; cyc++) begin
      #1;
      if (!EX_stall_o) break;
      stalls++;
      @(posedge clk_i); #1;
      if (sample() !== bubble_of(held)) bad++;
    end
    @(posedge clk_i); #1;
    check(name, exp_q.pop_front());
    check_val({name, "_stall_cycles"}, stalls, 33);
    check_val({name, "_bubbles"}, bad, 0);
  endtask

  in_t v;
  in_t nop;
  exp_t held;
  int bad;
  logic stall_seen;

  initial begin
    flush_i = 1'b0;
    n_rst_i = 1'b1;
    drive('0);
    #1 n_rst_i = 1'b0;
    #1;
    check("reset_outputs", '0);
    check_val("reset_stall", {31'd0, EX_stall_o}, 0);
    #10 n_rst_i = 1'b1;
    @(posedge clk_i); #1;

    v = mk_in(AluAdd, 32'd5, 32'h11, 32'hFFFF_FFFD, 1'b1); v.reg_dst = 1'b0;
    add_vec("add_imm", v, 32'd2, 1'b0);
    v = mk_in(AluSub, 32'd7, 32'd7, 32'd4, 1'b0); v.br = 1'b1; v.bne = 1'b1; v.rw = 1'b0;
    add_vec("bne_equal", v, 32'd0, 1'b0);
    v = mk_in(AluSub, 32'd7, 32'd8, 32'd4, 1'b0); v.br = 1'b1; v.bne = 1'b1; v.rw = 1'b0;
    add_vec("bne_differ", v, 32'hFFFF_FFFF, 1'b1);
    v = mk_in(AluSub, 32'd9, 32'd9, 32'hFFFF_FFFE, 1'b0); v.br = 1'b1; v.rw = 1'b0;
    add_vec("beq_back", v, 32'd0, 1'b1);
    add_vec("sra", mk_in(AluSra, 32'h8000_0000, 32'd0, 32'd4, 1'b1), 32'hF800_0000, 1'b0);
    add_vec("slt", mk_in(AluSlt, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0), 32'd1, 1'b0);
    add_vec("sltu", mk_in(AluSltu, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0), 32'd0, 1'b0);
    v = mk_in(AluAnd, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'd0, 1'b0); v.mr = MemWord; v.m2r = 1'b1;
    add_vec("and_load", v, 32'h00F0_1234, 1'b0);
    v = mk_in(AluOr, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'd0, 1'b0); v.mw = MemByte; v.rw = 1'b0;
    add_vec("or_store", v, 32'hFFF0_FFFF, 1'b0);
    v = mk_in(AluXor, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'd0, 1'b0); v.mr = MemHalf;
    add_vec("xor", v, 32'hFF00_EDCB, 1'b0);
    add_vec("nor", mk_in(AluNor, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'd0, 1'b0), 32'h000F_0000,
            1'b0);
    add_vec("sll", mk_in(AluSll, 32'd1, 32'd0, 32'd31, 1'b1), 32'h8000_0000, 1'b0);
    add_vec("srl_shamt_mask", mk_in(AluSrl, 32'h8000_0000, 32'h24, 32'd0, 1'b0),
            32'h0800_0000, 1'b0);
    add_vec("lui", mk_in(AluLui, 32'd0, 32'd5, 32'h1234, 1'b1), 32'h1234_0000, 1'b0);
    add_vec("sub_wrap", mk_in(AluSub, 32'd0, 32'd1, 32'd0, 1'b0), 32'hFFFF_FFFF, 1'b0);
    add_vec("add_ovf", mk_in(AluAdd, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0), 32'h8000_0000, 1'b0);

    stall_seen = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].in);
      exp_q.push_back(model(vecs[i].in, vecs[i].alu, vecs[i].do_br));
      #1;
      if (EX_stall_o) stall_seen = 1'b1;
      @(posedge clk_i); #1;
      check(names[i], exp_q.pop_front());
    end
    check_val("table_stall_low", {31'd0, stall_seen}, 0);

    // Flush on an ordinary instruction: bubble, data held.
    held = sample();
    drive(mk_in(AluAdd, 32'd40, 32'd2, 32'd0, 1'b0));
    flush_i = 1'b1;
    #1 check_val("flush_add_stall", {31'd0, EX_stall_o}, 0);
    @(posedge clk_i); #1;
    check("flush_add_bubble", bubble_of(held));
    flush_i = 1'b0;

    // Two MULs back to back; the second uses the immediate as multiplier.
    v = mk_in(AluMul, 32'hFFFF_FFFF, 32'd3, 32'd0, 1'b0); v.rd = 5'd5;
    run_mul("mul_neg1x3", v, 32'hFFFF_FFFD);
    run_mul("mul_b2b_imm", mk_in(AluMul, 32'd6, 32'd0, 32'd7, 1'b1), 32'd42);

    // MUL aborted by flush in its tenth BUSY cycle.
    held = sample();
    drive(mk_in(AluMul, 32'd3, 32'd5, 32'd0, 1'b0));
    for (int c = 0; c < 10; c++) @(posedge clk_i);
    #1;
    check_val("mulflush_stall_before", {31'd0, EX_stall_o}, 1);
    flush_i = 1'b1;
    #1 check_val("mulflush_stall_during", {31'd0, EX_stall_o}, 0);
    @(posedge clk_i); #1;
    check("mulflush_bubble", bubble_of(held));
    flush_i = 1'b0;
    nop = mk_in(AluAdd, 32'd1, 32'd1, 32'd0, 1'b0);
    drive(nop);
    #1 check_val("mulflush_stall_after", {31'd0, EX_stall_o}, 0);
    bad = 0;
    for (int c = 0; c < 36; c++) begin
      @(posedge clk_i); #1;
      if (sample() !== model(nop, 32'd2, 1'b1) || EX_stall_o) bad++;
    end
    check_val("mulflush_no_product", bad, 0);

    // Reset in the middle of a MUL.
    v = mk_in(AluAdd, 32'h1234, 32'd1, 32'd0, 1'b0);
    drive(v);
    @(posedge clk_i); #1;
    check("pre_reset_add", model(v, 32'h1235, 1'b0));
    drive(mk_in(AluMul, 32'd6, 32'd7, 32'd0, 1'b0));
    for (int c = 0; c < 5; c++) @(posedge clk_i);
    #2 n_rst_i = 1'b0;
    #1;
    check("mulreset_outputs", '0);
    check_val("mulreset_stall", {31'd0, EX_stall_o}, 0);
    v = mk_in(AluAdd, 32'd100, 32'd1, 32'd0, 1'b0);
    drive(v);
    exp_q.push_back(model(v, 32'd101, 1'b0));
    #1 n_rst_i = 1'b1;
    @(posedge clk_i); #1;
    check("post_reset_add", exp_q.pop_front());
    bad = 0;
    for (int c = 0; c < 35; c++) begin
      if (EX_stall_o) bad++;
      @(posedge clk_i); #1;
      if (sample() !== model(v, 32'd101, 1'b0)) bad++;
    end
    check_val("mulreset_no_product", bad, 0);

    check_val("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
